// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences the single-port data memory between the MW-stage LSU and an aux (DMA/debug) port.
// Define DMEM_TIMEOUT_EN to add the mem_ack timeout (bus_err + 32'hDEADBEEF completion).
module dmem_arbiter #(
  parameter int MAX_LSU_STREAK = 4
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_cs,
  input  logic        lsu_wr,
  input  logic [3:0]  lsu_mask,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        Stall_MW,
  output logic        lsu_valid,
  output logic [31:0] lsu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [3:0]  aux_mask,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);

  typedef enum logic [2:0] {IDLE, LSU_BUSY, AUX_BUSY, LSU_DONE, AUX_DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          we_q, we_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          lsuWin, auxWin;

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // LSU keeps priority until it has taken MAX_LSU_STREAK grants in a row against a waiting aux
  assign lsuWin = (state_q == IDLE) && !lsu_cs &&
                  (!aux_req || (streak_q < SW'(MAX_LSU_STREAK)));
  assign auxWin = (state_q == IDLE) && aux_req && !lsuWin;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (lsuWin) begin
          state_d = LSU_BUSY;
          we_d    = ~lsu_wr;
          mask_d  = lsu_mask;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
        end else if (auxWin) begin
          state_d = AUX_BUSY;
          we_d    = aux_we;
          mask_d  = aux_mask;
          addr_d  = aux_addr;
          wdata_d = aux_wdata;
        end
`ifdef DMEM_TIMEOUT_EN
        tmo_d = '0;
        err_d = 1'b0;
`endif
      end
      LSU_BUSY, AUX_BUSY: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = (state_q == LSU_BUSY) ? LSU_DONE : AUX_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 32'hDEADBEEF;
          err_d   = 1'b1;
          state_d = (state_q == LSU_BUSY) ? LSU_DONE : AUX_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!aux_req || auxWin) begin
      streak_d = '0;
    end else if (lsuWin && (streak_q < SW'(MAX_LSU_STREAK))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // Combinational outputs are held low during reset so every output reads 0 while rst is asserted
  assign Stall_MW   = rst && !lsu_cs && (state_q != LSU_DONE);
  assign aux_gnt    = rst && auxWin;
  assign mem_req    = (state_q == LSU_BUSY) || (state_q == AUX_BUSY);
  assign mem_we     = we_q;
  assign mem_mask   = mask_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign lsu_valid  = (state_q == LSU_DONE);
  assign lsu_rdata  = lsu_valid ? rdata_q : '0;
  assign aux_rvalid = (state_q == AUX_DONE);
  assign aux_rdata  = aux_rvalid ? rdata_q : '0;

`ifdef DMEM_TIMEOUT_EN
  assign bus_err = err_q && (lsu_valid || aux_rvalid);
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter, checked every cycle against a transaction-level model.
// Define DMEM_TIMEOUT_EN to also exercise the ack timeout with TIMEOUT_CYCLES=8.
module tb_dmem_arbiter;

  localparam int MAX_STREAK = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_cs, lsu_wr, aux_req, aux_we, mem_ack;
  logic [3:0]  lsu_mask, aux_mask;
  logic [31:0] lsu_addr, lsu_wdata, aux_addr, aux_wdata, mem_rdata;
  logic        Stall_MW, lsu_valid, aux_gnt, aux_rvalid, mem_req, mem_we, bus_err;
  logic [3:0]  mem_mask;
  logic [31:0] lsu_rdata, aux_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_LSU_STREAK(MAX_STREAK)
`ifdef DMEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_cs(lsu_cs), .lsu_wr(lsu_wr), .lsu_mask(lsu_mask), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .Stall_MW(Stall_MW), .lsu_valid(lsu_valid), .lsu_rdata(lsu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_mask(aux_mask), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory, who completes this cycle, and the LSU streak.
  // Owner/done codes: 0 = nobody, 1 = LSU, 2 = aux.
  int          mOwner = 0;
  int          mDone  = 0;
  int          mStreak = 0;
  int          mWait  = 0;
  bit          mErr   = 1'b0;
  bit          mLoad  = 1'b0;
  logic        mWe    = 1'b0;
  logic [3:0]  mMask  = '0;
  logic [31:0] mAddr  = '0;
  logic [31:0] mWdata = '0;
  logic [31:0] mData  = '0;

  function automatic bit modelIdle();
    return (mOwner == 0) && (mDone == 0);
  endfunction

  function automatic bit lsuTakes();
    return modelIdle() && !lsu_cs && (!aux_req || (mStreak < MAX_STREAK));
  endfunction

  function automatic bit auxTakes();
    return modelIdle() && aux_req && !lsuTakes();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mOwner  <= 0;
      mDone   <= 0;
      mStreak <= 0;
      mWait   <= 0;
      mErr    <= 1'b0;
    end else begin
      if (mDone != 0) begin
        mDone <= 0;
        mErr  <= 1'b0;
      end else if (mOwner != 0) begin
        if (mem_ack) begin
          mData  <= mem_rdata;
          mDone  <= mOwner;
          mOwner <= 0;
        end
`ifdef DMEM_TIMEOUT_EN
        else begin
          mWait <= mWait + 1;
          if (mWait + 1 == TMO) begin
            mData  <= 32'hDEADBEEF;
            mErr   <= 1'b1;
            mDone  <= mOwner;
            mOwner <= 0;
          end
        end
`endif
      end else if (lsuTakes()) begin
        mOwner <= 1;
        mLoad  <= lsu_wr;
        mWe    <= !lsu_wr;
        mMask  <= lsu_mask;
        mAddr  <= lsu_addr;
        mWdata <= lsu_wdata;
        mWait  <= 0;
      end else if (auxTakes()) begin
        mOwner <= 2;
        mLoad  <= !aux_we;
        mWe    <= aux_we;
        mMask  <= aux_mask;
        mAddr  <= aux_addr;
        mWdata <= aux_wdata;
        mWait  <= 0;
      end
      if (!aux_req || auxTakes()) mStreak <= 0;
      else if (lsuTakes()) mStreak <= (mStreak + 1 > MAX_STREAK) ? MAX_STREAK : mStreak + 1;
    end
  end

  // Per-cycle comparison against the model, sampled away from the rising edge
  always @(negedge clk) begin
    checkOutput("stall_mw", 32'(Stall_MW), 32'(rst && !lsu_cs && (mDone != 1)));
    checkOutput("aux_gnt", 32'(aux_gnt), 32'(rst && auxTakes()));
    checkOutput("mem_req", 32'(mem_req), 32'(mOwner != 0));
    checkOutput("lsu_valid", 32'(lsu_valid), 32'(mDone == 1));
    checkOutput("aux_rvalid", 32'(aux_rvalid), 32'(mDone == 2));
    checkOutput("bus_err", 32'(bus_err), 32'(mErr && (mDone != 0)));
    if (mOwner != 0) begin
      checkOutput("mem_we", 32'(mem_we), 32'(mWe));
      checkOutput("mem_mask", 32'(mem_mask), 32'(mMask));
      checkOutput("mem_addr", mem_addr, mAddr);
      checkOutput("mem_wdata", mem_wdata, mWdata);
    end
    if (mDone == 1 && mLoad) checkOutput("lsu_rdata", lsu_rdata, mData);
    if (mDone == 2 && mLoad) checkOutput("aux_rdata", aux_rdata, mData);
  end

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        areq;
    logic        awe;
    logic [3:0]  amask;
    logic [31:0] aaddr;
    logic [31:0] awdata;
    logic        ack;
    logic [31:0] rdata;
  } stim_t;

  stim_t s;

  task automatic applyStimulus(input stim_t v);
    lsu_cs    = v.cs;
    lsu_wr    = v.wr;
    lsu_mask  = v.mask;
    lsu_addr  = v.addr;
    lsu_wdata = v.wdata;
    aux_req   = v.areq;
    aux_we    = v.awe;
    aux_mask  = v.amask;
    aux_addr  = v.aaddr;
    aux_wdata = v.awdata;
    mem_ack   = v.ack;
    mem_rdata = v.rdata;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    s = '0;
    s.cs = 1'b1;
    s.wr = 1'b1;
    applyStimulus(s);
    repeat (2) nextCycle();
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_lsu_valid", 32'(lsu_valid), 0);
    checkOutput("rst_aux_gnt", 32'(aux_gnt), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b1;
    nextCycle();

    // Zero-wait LSU load
    s.cs = 1'b0; s.wr = 1'b1; s.mask = 4'hF; s.addr = 32'h100;
    applyStimulus(s);
    checkOutput("t1_c0_stall", 32'(Stall_MW), 1);
    checkOutput("t1_c0_mem_req", 32'(mem_req), 0);
    nextCycle();
    s.ack = 1'b1; s.rdata = 32'h12345678;
    applyStimulus(s);
    checkOutput("t1_c1_mem_req", 32'(mem_req), 1);
    checkOutput("t1_c1_mem_we", 32'(mem_we), 0);
    checkOutput("t1_c1_mem_addr", mem_addr, 32'h100);
    checkOutput("t1_c1_stall", 32'(Stall_MW), 1);
    nextCycle();
    s.ack = 1'b0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("t1_c2_valid", 32'(lsu_valid), 1);
    checkOutput("t1_c2_rdata", lsu_rdata, 32'h12345678);
    checkOutput("t1_c2_stall", 32'(Stall_MW), 0);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    checkOutput("t1_c3_valid", 32'(lsu_valid), 0);
    nextCycle();

    // LSU store with a 3-cycle ack delay
    s.cs = 1'b0; s.wr = 1'b0; s.mask = 4'b1000; s.addr = 32'h203; s.wdata = 32'hAB000000;
    applyStimulus(s);
    nextCycle();
    for (int i = 1; i <= 4; i++) begin
      s.ack = (i == 4); s.rdata = 32'hFFFFFFFF;
      applyStimulus(s);
      checkOutput("t2_mem_req", 32'(mem_req), 1);
      checkOutput("t2_mem_we", 32'(mem_we), 1);
      checkOutput("t2_mem_mask", 32'(mem_mask), 32'b1000);
      checkOutput("t2_mem_addr", mem_addr, 32'h203);
      checkOutput("t2_mem_wdata", mem_wdata, 32'hAB000000);
      checkOutput("t2_early_valid", 32'(lsu_valid), 0);
      nextCycle();
    end
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t2_c5_valid", 32'(lsu_valid), 1);
    checkOutput("t2_c5_stall", 32'(Stall_MW), 0);
    nextCycle();
    s.cs = 1'b1; s.wr = 1'b1;
    applyStimulus(s);
    nextCycle();

    // Four LSU grants against a waiting aux read, then aux wins, then LSU again
    s.areq = 1'b1; s.awe = 1'b0; s.amask = 4'hF; s.aaddr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      s.cs = 1'b0; s.wr = 1'b1; s.mask = 4'hF; s.addr = 32'h1000 + k * 4;
      applyStimulus(s);
      checkOutput("t3_lsu_first_gnt", 32'(aux_gnt), 0);
      nextCycle();
      s.ack = 1'b1; s.rdata = 32'h50 + k;
      applyStimulus(s);
      checkOutput("t3_lsu_addr", mem_addr, 32'h1000 + k * 4);
      nextCycle();
      s.ack = 1'b0;
      applyStimulus(s);
      checkOutput("t3_lsu_valid", 32'(lsu_valid), 1);
      nextCycle();
    end
    s.addr = 32'h2000;
    applyStimulus(s);
    checkOutput("t3_fifth_aux_gnt", 32'(aux_gnt), 1);
    checkOutput("t3_fifth_stall", 32'(Stall_MW), 1);
    nextCycle();
    s.areq = 1'b0; s.ack = 1'b1; s.rdata = 32'hA5A5A5A5;
    applyStimulus(s);
    checkOutput("t3_aux_addr", mem_addr, 32'h400);
    checkOutput("t3_aux_we", 32'(mem_we), 0);
    nextCycle();
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t3_aux_rvalid", 32'(aux_rvalid), 1);
    checkOutput("t3_aux_rdata", aux_rdata, 32'hA5A5A5A5);
    checkOutput("t3_aux_stall", 32'(Stall_MW), 1);
    nextCycle();
    applyStimulus(s);
    checkOutput("t3_after_aux_gnt", 32'(aux_gnt), 0);
    nextCycle();
    s.ack = 1'b1; s.rdata = 32'h2222;
    applyStimulus(s);
    checkOutput("t3_lsu_again_addr", mem_addr, 32'h2000);
    nextCycle();
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t3_lsu_again_rdata", lsu_rdata, 32'h2222);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    nextCycle();

    // Simultaneous LSU load and aux write with streak 0
    s.cs = 1'b0; s.wr = 1'b1; s.mask = 4'hF; s.addr = 32'h300;
    s.areq = 1'b1; s.awe = 1'b1; s.amask = 4'b0011; s.aaddr = 32'h500; s.awdata = 32'hCAFEF00D;
    applyStimulus(s);
    checkOutput("t4_c0_aux_gnt", 32'(aux_gnt), 0);
    nextCycle();
    s.ack = 1'b1; s.rdata = 32'h11112222;
    applyStimulus(s);
    checkOutput("t4_c1_addr", mem_addr, 32'h300);
    nextCycle();
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t4_c2_valid", 32'(lsu_valid), 1);
    checkOutput("t4_c2_aux_gnt", 32'(aux_gnt), 0);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    checkOutput("t4_c3_aux_gnt", 32'(aux_gnt), 1);
    nextCycle();
    s.areq = 1'b0; s.ack = 1'b1; s.rdata = 32'h0BADF00D;
    applyStimulus(s);
    checkOutput("t4_c4_we", 32'(mem_we), 1);
    checkOutput("t4_c4_wdata", mem_wdata, 32'hCAFEF00D);
    checkOutput("t4_c4_mask", 32'(mem_mask), 32'b0011);
    nextCycle();
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t4_c5_rvalid", 32'(aux_rvalid), 1);
    nextCycle();
    applyStimulus(s);
    nextCycle();

    // Reset in the middle of an unacknowledged LSU access
    s.cs = 1'b0; s.addr = 32'h600;
    applyStimulus(s);
    nextCycle();
    applyStimulus(s);
    checkOutput("t5_busy_req", 32'(mem_req), 1);
    nextCycle();
    applyStimulus(s);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_mem_req", 32'(mem_req), 0);
    checkOutput("t5_rst_stall", 32'(Stall_MW), 0);
    checkOutput("t5_rst_mem_addr", mem_addr, 0);
    checkOutput("t5_rst_valid", 32'(lsu_valid), 0);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    nextCycle();
    rst = 1'b1;
    applyStimulus(s);
    checkOutput("t5_no_spurious_valid", 32'(lsu_valid), 0);
    nextCycle();
    s.cs = 1'b0; s.addr = 32'h700;
    applyStimulus(s);
    nextCycle();
    s.ack = 1'b1; s.rdata = 32'h77;
    applyStimulus(s);
    checkOutput("t5_new_addr", mem_addr, 32'h700);
    nextCycle();
    s.ack = 1'b0;
    applyStimulus(s);
    checkOutput("t5_new_rdata", lsu_rdata, 32'h77);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    nextCycle();

`ifdef DMEM_TIMEOUT_EN
    // No ack at all: the access must give up after TMO wait cycles
    s.cs = 1'b0; s.addr = 32'h800;
    applyStimulus(s);
    nextCycle();
    for (int i = 1; i <= TMO; i++) begin
      applyStimulus(s);
      checkOutput("t6_wait_req", 32'(mem_req), 1);
      checkOutput("t6_wait_err", 32'(bus_err), 0);
      nextCycle();
    end
    applyStimulus(s);
    checkOutput("t6_valid", 32'(lsu_valid), 1);
    checkOutput("t6_bus_err", 32'(bus_err), 1);
    checkOutput("t6_rdata", lsu_rdata, 32'hDEADBEEF);
    checkOutput("t6_req_dropped", 32'(mem_req), 0);
    nextCycle();
    s.cs = 1'b1;
    applyStimulus(s);
    checkOutput("t6_err_pulse", 32'(bus_err), 0);
    nextCycle();
`endif

    repeat (2) nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
